// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour width and packed RGB type for the
// vga_sync_ctrl timing generator and its axis counters.
package vga_pkg;

  localparam int COLOR_W = 4;

  // 640x480@60 default geometry, per axis: visible, front porch, sync, back porch
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb12_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One VGA axis: wrapping counter with increment enable, wrap flag and
// visible/sync region decode of both the current and the next count.
module vga_axis_cnt #(
  parameter int W    = 10,
  parameter int VIS  = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic         wrap_o,
  output logic         vis_o,
  output logic         sync_o,
  output logic [W-1:0] cnt_nx_o,
  output logic         vis_nx_o
);

  localparam logic [W-1:0] LAST    = W'(VIS + FP + SYNC + BP - 1);
  localparam logic [W-1:0] VIS_END = W'(VIS);
  localparam logic [W-1:0] SYNC_LO = W'(VIS + FP);
  localparam logic [W-1:0] SYNC_HI = W'(VIS + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (inc_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign vis_o    = (cnt_q < VIS_END);
  assign sync_o   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
  assign cnt_nx_o = cnt_d;
  assign vis_nx_o = (cnt_d < VIS_END);

endmodule

// File: rtl/vga_sync_ctrl.sv
// 640x480@60 VGA timing generator with a one-pixel registered colour stage.
// Optional macro VGA_BORDER_TEST_EN forces 4'hF on the visible frame edge.
module vga_sync_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] Red_in,
  input  logic [COLOR_W-1:0] Green_in,
  input  logic [COLOR_W-1:0] Blue_in,
  output logic [9:0]         Hcnt,
  output logic [8:0]         Vcnt,
  output logic               frame_tick,
  output logic               hs,
  output logic               vs,
  output logic               rdn,
  output logic [COLOR_W-1:0] Red,
  output logic [COLOR_W-1:0] Green,
  output logic [COLOR_W-1:0] Blue
);

  localparam int H_SUM = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_SUM = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);

  if (CLK_DIV < 2 || CLK_DIV > 15) begin : g_bad_div
    $error("vga_sync_ctrl: CLK_DIV must be in 2..15");
  end
  if (H_SUM > 1023 || V_SUM > 1023) begin : g_bad_tot
    $error("vga_sync_ctrl: axis totals must fit 10 bits");
  end
  if (H_VIS > 1023 || V_VIS > 512) begin : g_bad_vis
    $error("vga_sync_ctrl: visible area exceeds Hcnt/Vcnt width");
  end

  logic [3:0] div_q, div_d;
  logic       pix_ce;

  logic       h_wrap, h_vis, h_sync, h_vis_nx;
  logic       v_wrap_unused, v_vis, v_sync, v_vis_nx;
  logic [9:0] h_nx, v_nx;

  logic [9:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       tick_q, tick_d;
  logic       hs_q, vs_q, rdn_q;
  logic       pix_vis;
  rgb12_t     rgb_q, rgb_d;

  assign pix_ce = (div_q == DIV_LAST);
  assign div_d  = pix_ce ? 4'd0 : div_q + 4'd1;

  vga_axis_cnt #(
    .W(10), .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .inc_i(pix_ce),
    .wrap_o(h_wrap), .vis_o(h_vis), .sync_o(h_sync),
    .cnt_nx_o(h_nx), .vis_nx_o(h_vis_nx)
  );

  vga_axis_cnt #(
    .W(10), .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .inc_i(h_wrap),
    .wrap_o(v_wrap_unused), .vis_o(v_vis), .sync_o(v_sync),
    .cnt_nx_o(v_nx), .vis_nx_o(v_vis_nx)
  );

  // Coordinates follow the counter; sync/colour describe the pixel just left.
  always_comb begin
    hcnt_d  = h_vis_nx ? h_nx : 10'd0;
    vcnt_d  = v_vis_nx ? v_nx[8:0] : 9'd0;
    tick_d  = pix_ce && h_wrap && (v_nx == V_VIS_L);
    pix_vis = h_vis && v_vis;
    rgb_d   = pix_vis ? {Red_in, Green_in, Blue_in} : '0;
`ifdef VGA_BORDER_TEST_EN
    // hcnt_q/vcnt_q still hold the coordinate of the pixel being sampled
    if (pix_vis && (hcnt_q == 10'd0 || hcnt_q == 10'(H_VIS - 1) ||
                    vcnt_q == 9'd0  || vcnt_q == 9'(V_VIS - 1))) begin
      rgb_d = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      tick_q <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rdn_q  <= 1'b1;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      if (pix_ce) begin
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        hs_q   <= ~h_sync;
        vs_q   <= ~v_sync;
        rdn_q  <= ~pix_vis;
        rgb_q  <= rgb_d;
      end
    end
  end

  assign Hcnt       = hcnt_q;
  assign Vcnt       = vcnt_q;
  assign frame_tick = tick_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign rdn        = rdn_q;
  assign Red        = rgb_q.r;
  assign Green      = rgb_q.g;
  assign Blue       = rgb_q.b;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Self-checking bench for vga_sync_ctrl on a reduced geometry, compared
// cycle by cycle against an arithmetic model of the sweep.
module tb_vga_sync_ctrl;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 20, H_FP = 3, H_SYNC = 4, H_BP = 3;
  localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLK  = H_TOT * CLK_DIV;
  localparam int FRAME_CLK = V_TOT * LINE_CLK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Red_in = '0, Green_in = '0, Blue_in = '0;
  logic [9:0] Hcnt;
  logic [8:0] Vcnt;
  logic       frame_tick, hs, vs, rdn;
  logic [3:0] Red, Green, Blue;

  vga_sync_ctrl #(
    .CLK_DIV(CLK_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
    .Hcnt(Hcnt), .Vcnt(Vcnt), .frame_tick(frame_tick),
    .hs(hs), .vs(vs), .rdn(rdn),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] hc;
    logic [8:0] vc;
    logic       ft;
    logic       hs;
    logic       vs;
    logic       rdn;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } obs_t;

  localparam obs_t RST_EXP = '{hc: 10'd0, vc: 9'd0, ft: 1'b0, hs: 1'b1, vs: 1'b1,
                               rdn: 1'b1, r: 4'd0, g: 4'd0, b: 4'd0};

  int total = 0;
  int bad   = 0;
  int k     = 0;  // clk edges since reset was last released
  logic [3:0] key_r = '0, key_g = '0, key_b = '0;

  // Renderer: colour is a keyed function of the coordinate being displayed.
  function automatic obs_t model(int kk);
    obs_t e;
    int n, h, v, m, hm, vm;
    logic vis;
    n = kk / CLK_DIV;
    h = n % H_TOT;
    v = (n / H_TOT) % V_TOT;
    e = RST_EXP;
    e.hc = (h < H_VIS) ? 10'(h) : 10'd0;
    e.vc = (v < V_VIS) ? 9'(v) : 9'd0;
    e.ft = (kk > 0) && (kk % CLK_DIV == 0) && (h == 0) && (v == V_VIS);
    if (n > 0) begin
      m  = n - 1;
      hm = m % H_TOT;
      vm = (m / H_TOT) % V_TOT;
      e.hs  = !((hm >= H_VIS + H_FP) && (hm < H_VIS + H_FP + H_SYNC));
      e.vs  = !((vm >= V_VIS + V_FP) && (vm < V_VIS + V_FP + V_SYNC));
      vis   = (hm < H_VIS) && (vm < V_VIS);
      e.rdn = !vis;
      if (vis) begin
        e.r = 4'(hm) ^ key_r;
        e.g = 4'(vm) ^ key_g;
        e.b = key_b;
`ifdef VGA_BORDER_TEST_EN
        if (hm == 0 || hm == H_VIS - 1 || vm == 0 || vm == V_VIS - 1) begin
          e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
        end
`endif
      end
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.hc = Hcnt; o.vc = Vcnt; o.ft = frame_tick;
    o.hs = hs; o.vs = vs; o.rdn = rdn;
    o.r = Red; o.g = Green; o.b = Blue;
    return o;
  endfunction

  // Present colour only for the sampling edge; garbage on all other cycles.
  task automatic step();
    if (!rst && ((k + 1) % CLK_DIV == 0)) begin
      Red_in   = Hcnt[3:0] ^ key_r;
      Green_in = Vcnt[3:0] ^ key_g;
      Blue_in  = key_b;
    end else begin
      Red_in   = 4'($urandom);
      Green_in = 4'($urandom);
      Blue_in  = 4'($urandom);
    end
    @(posedge clk);
    #1;
    k = rst ? 0 : k + 1;
  endtask

  task automatic settle_keys();
    do step(); while (k % CLK_DIV != 0);
  endtask

  task automatic test_reset();
    obs_t o, e;
    key_r = 4'($urandom); key_g = 4'($urandom); key_b = 4'($urandom);
    rst = 1'b1;
    repeat (3) begin
      step();
      o = observe();
      total++;
      if (o !== RST_EXP) begin
        bad++;
        $display("FAIL reset_hold got=%h want=%h", o, RST_EXP);
      end
    end
    rst = 1'b0;
    repeat (3 * CLK_DIV + 2) begin
      step();
      o = observe();
      e = model(k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_release k=%0d got=%h want=%h", k, o, e);
      end
      if (k == CLK_DIV - 1 || k == CLK_DIV) begin
        total++;
        if (Hcnt !== ((k == CLK_DIV) ? 10'd1 : 10'd0)) begin
          bad++;
          $display("FAIL first_pix_ce k=%0d Hcnt=%0d want=%0d", k, Hcnt, (k == CLK_DIV) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_line_timing();
    obs_t o, e;
    int hf0 = -1, hf1 = -1, hr = -1, rf = -1, rr = -1;
    logic phs, prdn;
    phs = hs; prdn = rdn;
    for (int i = 0; i < 4 * LINE_CLK && (hf1 < 0 || rr < 0); i++) begin
      step();
      o = observe();
      e = model(k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL line_cycle k=%0d got=%h want=%h", k, o, e);
      end
      if (phs && !hs) begin
        if (hf0 < 0) hf0 = k;
        else if (hf1 < 0) hf1 = k;
      end
      if (!phs && hs && hf0 >= 0 && hr < 0) hr = k;
      if (prdn && !rdn && rf < 0) rf = k;
      if (!prdn && rdn && rf >= 0 && rr < 0) rr = k;
      phs = hs; prdn = rdn;
    end
    total++;
    if (hf1 - hf0 != LINE_CLK) begin
      bad++;
      $display("FAIL hs_period clk=%0d want=%0d", hf1 - hf0, LINE_CLK);
    end
    total++;
    if (hr - hf0 != H_SYNC * CLK_DIV) begin
      bad++;
      $display("FAIL hs_low clk=%0d want=%0d", hr - hf0, H_SYNC * CLK_DIV);
    end
    total++;
    if (rr - rf != H_VIS * CLK_DIV) begin
      bad++;
      $display("FAIL rdn_low clk=%0d want=%0d", rr - rf, H_VIS * CLK_DIV);
    end
    total++;
    if (rf < 0 || (rf % LINE_CLK) != CLK_DIV) begin
      bad++;
      $display("FAIL rdn_start k=%0d want line_offset=%0d", rf, CLK_DIV);
    end
  endtask

  task automatic test_frame_timing();
    obs_t o, e;
    int vf0 = -1, vf1 = -1, vr = -1, ticks = 0, tk = -1;
    logic pvs;
    pvs = vs;
    for (int i = 0; i < 3 * FRAME_CLK && vf1 < 0; i++) begin
      step();
      o = observe();
      e = model(k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL frame_cycle k=%0d got=%h want=%h", k, o, e);
      end
      if (pvs && !vs) begin
        if (vf0 < 0) vf0 = k;
        else vf1 = k;
      end
      if (!pvs && vs && vf0 >= 0 && vr < 0) vr = k;
      if (frame_tick && vf0 >= 0 && vf1 < 0) begin
        ticks++;
        if (tk < 0) tk = k;
      end
      pvs = vs;
    end
    total++;
    if (vf1 - vf0 != FRAME_CLK) begin
      bad++;
      $display("FAIL vs_period clk=%0d want=%0d", vf1 - vf0, FRAME_CLK);
    end
    total++;
    if (vr - vf0 != V_SYNC * LINE_CLK) begin
      bad++;
      $display("FAIL vs_low clk=%0d want=%0d", vr - vf0, V_SYNC * LINE_CLK);
    end
    total++;
    if (ticks != 1) begin
      bad++;
      $display("FAIL tick_count got=%0d want=1", ticks);
    end
    total++;
    if (tk < 0 || (tk % FRAME_CLK) != V_VIS * LINE_CLK) begin
      bad++;
      $display("FAIL tick_position k=%0d want frame_offset=%0d", tk, V_VIS * LINE_CLK);
    end
  endtask

  task automatic test_colour_path();
    obs_t o, e;
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        key_r = 4'h0; key_g = 4'h0; key_b = 4'h5;
      end else begin
        key_r = 4'($urandom); key_g = 4'($urandom); key_b = 4'($urandom);
      end
      settle_keys();
      repeat (3 * LINE_CLK + $urandom_range(LINE_CLK, 0)) begin
        step();
        o = observe();
        e = model(k);
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL colour_cycle p=%0d k=%0d got=%h want=%h", p, k, o, e);
        end
        if (rdn) begin
          total++;
          if ({Red, Green, Blue} !== 12'h000) begin
            bad++;
            $display("FAIL colour_blank k=%0d got=%h want=000", k, {Red, Green, Blue});
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int tk = -1;
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      step();
      o = observe();
      e = model(k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL mid_run k=%0d got=%h want=%h", k, o, e);
      end
      found = (Hcnt == 10'(H_VIS / 2)) && (Vcnt == 9'(V_VIS / 2));
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reach got=not_reached want=(%0d,%0d)", H_VIS / 2, V_VIS / 2);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    o = observe();
    total++;
    if (o !== RST_EXP) begin
      bad++;
      $display("FAIL mid_reset_values got=%h want=%h", o, RST_EXP);
    end
    for (int i = 0; i < FRAME_CLK && tk < 0; i++) begin
      step();
      o = observe();
      e = model(k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL mid_restart k=%0d got=%h want=%h", k, o, e);
      end
      if (frame_tick) tk = k;
    end
    total++;
    if (tk != V_VIS * LINE_CLK) begin
      bad++;
      $display("FAIL mid_first_tick k=%0d want=%0d", tk, V_VIS * LINE_CLK);
    end
  endtask

`ifdef VGA_BORDER_TEST_EN
  task automatic test_border();
    obs_t o, e;
    int fs = 0;
    key_r = 4'h0; key_g = 4'h0; key_b = 4'h0;
    settle_keys();
    repeat (FRAME_CLK + LINE_CLK) begin
      step();
      o = observe();
      e = model(k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL border_cycle k=%0d got=%h want=%h", k, o, e);
      end
      if (k % CLK_DIV == 0 && {Red, Green, Blue} == 12'hFFF) fs++;
    end
    total++;
    if (fs < 2 * (H_VIS + V_VIS) - 4) begin
      bad++;
      $display("FAIL border_count got=%0d want>=%0d", fs, 2 * (H_VIS + V_VIS) - 4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_colour_path();
    test_reset_mid();
`ifdef VGA_BORDER_TEST_EN
    test_border();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
